// File: rtl/scr1_dmi_resp_pkg.sv
// scr1_dmi_resp_pkg: shared definitions for the DMI responder.
//   - DMI geometry, register address map
//   - cmderr encodings, register bit indices
//   - command FSM state type, command support check
// Optional feature macro: SCR1_DMI_RESP_PROGBUF_EN (program buffer regs).
package scr1_dmi_resp_pkg;

  localparam int SCR1_DBG_DMI_ADDR_WIDTH = 7;
  localparam int SCR1_DBG_DMI_DATA_WIDTH = 32;

  localparam logic [6:0] DMI_DATA0      = 7'h04;
  localparam logic [6:0] DMI_DATA1      = 7'h05;
  localparam logic [6:0] DMI_DMCONTROL  = 7'h10;
  localparam logic [6:0] DMI_DMSTATUS   = 7'h11;
  localparam logic [6:0] DMI_ABSTRACTCS = 7'h16;
  localparam logic [6:0] DMI_COMMAND    = 7'h17;
  localparam logic [6:0] DMI_PROGBUF0   = 7'h20;
  localparam logic [6:0] DMI_PROGBUF1   = 7'h21;

  localparam logic [2:0] CMDERR_NONE       = 3'd0;
  localparam logic [2:0] CMDERR_BUSY       = 3'd1;
  localparam logic [2:0] CMDERR_NOTSUP     = 3'd2;
  localparam logic [2:0] CMDERR_EXC        = 3'd3;
  localparam logic [2:0] CMDERR_HALTRESUME = 3'd4;

  // dmcontrol
  localparam int DMCTL_DMACTIVE  = 0;
  localparam int DMCTL_NDMRESET  = 1;
  localparam int DMCTL_RESUMEREQ = 30;
  localparam int DMCTL_HALTREQ   = 31;
  // abstractcs
  localparam int ABS_CMDERR_LO   = 8;
  localparam int ABS_CMDERR_HI   = 10;
  // command
  localparam int CMD_POSTEXEC    = 18;
  localparam int CMD_TRANSFER    = 17;
  localparam int CMD_WRITE       = 16;

`ifdef SCR1_DMI_RESP_PROGBUF_EN
  localparam logic [4:0] PROGBUF_SIZE = 5'd2;
`else
  localparam logic [4:0] PROGBUF_SIZE = 5'd0;
`endif

  typedef enum logic {ST_IDLE, ST_BUSY} dm_state_e;

  // Only 32-bit Access Register commands are supported; postexec only
  // makes sense when a program buffer exists.
  function automatic logic cmd_supported(input logic [31:0] cmd);
    logic ok;
    ok = (cmd[31:24] == 8'd0) && (cmd[22:20] == 3'd2);
`ifndef SCR1_DMI_RESP_PROGBUF_EN
    if (cmd[CMD_POSTEXEC]) ok = 1'b0;
`endif
    return ok;
  endfunction

endpackage

// File: rtl/scr1_dmi_resp_cmd_fsm.sv
// scr1_dmi_resp_cmd_fsm: abstract command sequencer (IDLE/BUSY).
//   clk, clr_i        : clock, synchronous clear (reset or DM inactive)
//   cmd_wr_i          : DMI write to command, wdata_i carries the word
//   abs_wr_i          : DMI write to abstractcs (cmderr W1C)
//   data_wr_i         : DMI write to a register that is locked while busy
//   halted_i          : hart halted status
//   ack_i, err_i      : hart completion pulse and its error flag
//   busy_o            : busy as seen by this cycle's DMI access (ack applied)
//   ack_vld_o         : ack accepted this cycle
//   cmderr_o          : cmderr as seen by this cycle's DMI access
//   cmd_o             : latched command word
// Macro SCR1_DMI_RESP_PROGBUF_EN affects the command support check only.
module scr1_dmi_resp_cmd_fsm
  import scr1_dmi_resp_pkg::*;
(
  input  logic        clk,
  input  logic        clr_i,
  input  logic        cmd_wr_i,
  input  logic        abs_wr_i,
  input  logic        data_wr_i,
  input  logic [31:0] wdata_i,
  input  logic        halted_i,
  input  logic        ack_i,
  input  logic        err_i,
  output logic        busy_o,
  output logic        ack_vld_o,
  output logic [2:0]  cmderr_o,
  output logic [31:0] cmd_o
);

  dm_state_e   state_q;
  logic [2:0]  cmderr_q;
  logic [31:0] cmd_q;

  // The ack is folded in before the DMI access of the same cycle.
  assign ack_vld_o = (state_q == ST_BUSY) & ack_i;
  assign busy_o    = (state_q == ST_BUSY) & ~ack_i;
  assign cmderr_o  = (ack_vld_o & err_i) ? CMDERR_EXC : cmderr_q;
  assign cmd_o     = cmd_q;

  always_ff @(posedge clk) begin
    if (clr_i) begin
      state_q  <= ST_IDLE;
      cmderr_q <= CMDERR_NONE;
      cmd_q    <= '0;
    end else begin
      if (ack_vld_o) begin
        state_q  <= ST_IDLE;
        cmderr_q <= cmderr_o;
      end
      if (abs_wr_i) begin
        cmderr_q <= cmderr_o & ~wdata_i[ABS_CMDERR_HI:ABS_CMDERR_LO];
      end else if ((cmd_wr_i | data_wr_i) & busy_o) begin
        if (cmderr_o == CMDERR_NONE) cmderr_q <= CMDERR_BUSY;
      end else if (cmd_wr_i && cmderr_o == CMDERR_NONE) begin
        if (!cmd_supported(wdata_i)) begin
          cmderr_q <= CMDERR_NOTSUP;
        end else if (!halted_i) begin
          cmderr_q <= CMDERR_HALTRESUME;
        end else begin
          cmd_q   <= wdata_i;
          state_q <= ST_BUSY;
        end
      end
    end
  end

endmodule

// File: rtl/scr1_dmi_resp.sv
// scr1_dmi_resp: Debug Module side DMI responder.
//   clk, rst                      : clock, synchronous active-high reset
//   dmi2dm_*  / dm2dmi_*          : DMI request in, same-cycle response out
//   dm2hart_{haltreq,resumereq,ndmreset,dmactive}_o : run control levels
//   hart2dm_{halted,running}_i    : hart status
//   dm2hart_cmd_*, hart2dm_cmd_*  : abstract command req/ack handshake
// Parameter DATA_COUNT (1 or 2): number of dataN registers.
// Macro SCR1_DMI_RESP_PROGBUF_EN: adds progbuf0/1 at 0x20/0x21 and postexec.
module scr1_dmi_resp
  import scr1_dmi_resp_pkg::*;
#(
  parameter int DATA_COUNT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dmi2dm_req_i,
  input  logic        dmi2dm_wr_i,
  input  logic [SCR1_DBG_DMI_ADDR_WIDTH-1:0] dmi2dm_addr_i,
  input  logic [SCR1_DBG_DMI_DATA_WIDTH-1:0] dmi2dm_wdata_i,
  output logic        dm2dmi_resp_o,
  output logic [SCR1_DBG_DMI_DATA_WIDTH-1:0] dm2dmi_rdata_o,
  output logic        dm2hart_haltreq_o,
  output logic        dm2hart_resumereq_o,
  output logic        dm2hart_ndmreset_o,
  output logic        dm2hart_dmactive_o,
  input  logic        hart2dm_halted_i,
  input  logic        hart2dm_running_i,
  output logic        dm2hart_cmd_req_o,
  output logic [31:0] dm2hart_cmd_o,
  output logic [31:0] dm2hart_cmd_wdata_o,
  input  logic        hart2dm_cmd_ack_i,
  input  logic        hart2dm_cmd_err_i,
  input  logic [31:0] hart2dm_cmd_rdata_i
);

  logic        dmactive_q, ndmreset_q, haltreq_q, resumereq_q, resumeack_q;
  logic [31:0] data0_q, data1_q, data0_rd;
  logic        wr, wr_dmctl, dmctl_clr, clr;
  logic        wr_data0, wr_data1, wr_pbuf, data_wr;
  logic        busy, ack_vld, ack_upd;
  logic [2:0]  cmderr;
  logic [31:0] cmd;
  logic [31:0] rdata;

  assign wr        = dmi2dm_req_i & dmi2dm_wr_i;
  assign wr_dmctl  = wr & (dmi2dm_addr_i == DMI_DMCONTROL);
  assign dmctl_clr = wr_dmctl & ~dmi2dm_wdata_i[DMCTL_DMACTIVE];
  // Everything but dmcontrol is held clear while the DM is inactive.
  assign clr       = rst | ~dmactive_q | dmctl_clr;

  assign wr_data0  = wr & (dmi2dm_addr_i == DMI_DATA0);
  assign wr_data1  = wr & (dmi2dm_addr_i == DMI_DATA1) & (DATA_COUNT > 1);
`ifdef SCR1_DMI_RESP_PROGBUF_EN
  assign wr_pbuf   = wr & ((dmi2dm_addr_i == DMI_PROGBUF0) | (dmi2dm_addr_i == DMI_PROGBUF1));
`else
  assign wr_pbuf   = 1'b0;
`endif
  assign data_wr   = wr_data0 | wr_data1 | wr_pbuf;

  scr1_dmi_resp_cmd_fsm u_cmd_fsm (
    .clk       (clk),
    .clr_i     (clr),
    .cmd_wr_i  (wr & (dmi2dm_addr_i == DMI_COMMAND)),
    .abs_wr_i  (wr & (dmi2dm_addr_i == DMI_ABSTRACTCS)),
    .data_wr_i (data_wr),
    .wdata_i   (dmi2dm_wdata_i),
    .halted_i  (hart2dm_halted_i),
    .ack_i     (hart2dm_cmd_ack_i),
    .err_i     (hart2dm_cmd_err_i),
    .busy_o    (busy),
    .ack_vld_o (ack_vld),
    .cmderr_o  (cmderr),
    .cmd_o     (cmd)
  );

  // Successful register read returns its value into data0.
  assign ack_upd  = ack_vld & ~hart2dm_cmd_err_i & cmd[CMD_TRANSFER] & ~cmd[CMD_WRITE];
  assign data0_rd = ack_upd ? hart2dm_cmd_rdata_i : data0_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      dmactive_q  <= 1'b0;
      ndmreset_q  <= 1'b0;
      haltreq_q   <= 1'b0;
      resumereq_q <= 1'b0;
      resumeack_q <= 1'b0;
    end else begin
      if (resumereq_q & hart2dm_running_i) begin
        resumereq_q <= 1'b0;
        resumeack_q <= 1'b1;
      end
      if (wr_dmctl) begin
        dmactive_q <= dmi2dm_wdata_i[DMCTL_DMACTIVE];
        ndmreset_q <= dmi2dm_wdata_i[DMCTL_DMACTIVE] & dmi2dm_wdata_i[DMCTL_NDMRESET];
        haltreq_q  <= dmi2dm_wdata_i[DMCTL_DMACTIVE] & dmi2dm_wdata_i[DMCTL_HALTREQ];
        if (!dmi2dm_wdata_i[DMCTL_DMACTIVE]) begin
          resumereq_q <= 1'b0;
          resumeack_q <= 1'b0;
        end else if (dmi2dm_wdata_i[DMCTL_RESUMEREQ] & ~dmi2dm_wdata_i[DMCTL_HALTREQ]) begin
          resumereq_q <= 1'b1;
          resumeack_q <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      data0_q <= '0;
      data1_q <= '0;
    end else begin
      if (ack_upd)              data0_q <= hart2dm_cmd_rdata_i;
      if (wr_data0 & ~busy)     data0_q <= dmi2dm_wdata_i;
      if (wr_data1 & ~busy)     data1_q <= dmi2dm_wdata_i;
    end
  end

`ifdef SCR1_DMI_RESP_PROGBUF_EN
  logic [31:0] pbuf0_q, pbuf1_q;
  always_ff @(posedge clk) begin
    if (clr) begin
      pbuf0_q <= '0;
      pbuf1_q <= '0;
    end else if (wr_pbuf & ~busy) begin
      if (dmi2dm_addr_i == DMI_PROGBUF0) pbuf0_q <= dmi2dm_wdata_i;
      else                               pbuf1_q <= dmi2dm_wdata_i;
    end
  end
`endif

  always_comb begin
    rdata = '0;
    if (dmi2dm_req_i && !dmi2dm_wr_i) begin
      case (dmi2dm_addr_i)
        DMI_DATA0:      rdata = data0_rd;
        DMI_DATA1:      rdata = (DATA_COUNT > 1) ? data1_q : '0;
        DMI_DMCONTROL:  rdata = {haltreq_q, resumereq_q, 28'd0, ndmreset_q, dmactive_q};
        DMI_DMSTATUS:   rdata = {14'd0, {2{resumeack_q}}, 4'd0,
                                 {2{hart2dm_running_i}}, {2{hart2dm_halted_i}},
                                 1'b1, 3'd0, 4'd2};
        DMI_ABSTRACTCS: rdata = {3'd0, PROGBUF_SIZE, 11'd0, busy, 1'b0, cmderr,
                                 4'd0, 4'(DATA_COUNT)};
`ifdef SCR1_DMI_RESP_PROGBUF_EN
        DMI_PROGBUF0:   rdata = pbuf0_q;
        DMI_PROGBUF1:   rdata = pbuf1_q;
`endif
        default:        rdata = '0;
      endcase
    end
  end

  assign dm2dmi_resp_o       = dmi2dm_req_i;
  assign dm2dmi_rdata_o      = rdata;
  assign dm2hart_haltreq_o   = haltreq_q;
  assign dm2hart_resumereq_o = resumereq_q;
  assign dm2hart_ndmreset_o  = ndmreset_q;
  assign dm2hart_dmactive_o  = dmactive_q;
  // Drops in the ack cycle and as soon as reset is seen.
  assign dm2hart_cmd_req_o   = busy & ~rst;
  assign dm2hart_cmd_o       = cmd;
  assign dm2hart_cmd_wdata_o = data0_q;

endmodule

// File: tb/tb_scr1_dmi_resp.sv
module tb_scr1_dmi_resp;

  localparam int DC = 2;
`ifdef SCR1_DMI_RESP_PROGBUF_EN
  localparam logic PB = 1'b1;
`else
  localparam logic PB = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0, wr = 1'b0;
  logic [6:0]  addr = '0;
  logic [31:0] wdata = '0;
  logic        halted = 1'b0, running = 1'b0, ack = 1'b0, err = 1'b0;
  logic [31:0] ackdata = '0;
  logic        resp, haltreq_o, resumereq_o, ndmreset_o, dmactive_o, cmd_req_o;
  logic [31:0] rdata, cmd_o, cmd_wdata_o;

  always #5 clk = ~clk;

  scr1_dmi_resp #(.DATA_COUNT(DC)) dut (
    .clk(clk), .rst(rst),
    .dmi2dm_req_i(req), .dmi2dm_wr_i(wr), .dmi2dm_addr_i(addr), .dmi2dm_wdata_i(wdata),
    .dm2dmi_resp_o(resp), .dm2dmi_rdata_o(rdata),
    .dm2hart_haltreq_o(haltreq_o), .dm2hart_resumereq_o(resumereq_o),
    .dm2hart_ndmreset_o(ndmreset_o), .dm2hart_dmactive_o(dmactive_o),
    .hart2dm_halted_i(halted), .hart2dm_running_i(running),
    .dm2hart_cmd_req_o(cmd_req_o), .dm2hart_cmd_o(cmd_o), .dm2hart_cmd_wdata_o(cmd_wdata_o),
    .hart2dm_cmd_ack_i(ack), .hart2dm_cmd_err_i(err), .hart2dm_cmd_rdata_i(ackdata)
  );

  int n_vec = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference state: what a debugger would believe the DM holds.
  logic        m_act, m_ndm, m_hr, m_rr, m_ra, m_busy;
  logic [2:0]  m_cerr;
  logic [31:0] m_d0, m_d1, m_cmd, m_pb0, m_pb1;
  logic [31:0] last_rdata;
  logic        last_cmdreq;

  task automatic m_clear();
    {m_act, m_ndm, m_hr, m_rr, m_ra, m_busy} = '0;
    m_cerr = '0; m_d0 = '0; m_d1 = '0; m_cmd = '0; m_pb0 = '0; m_pb1 = '0;
  endtask

  function automatic logic [31:0] m_read(input logic [6:0] a, input logic b,
                                          input logic [2:0] ce, input logic [31:0] d0);
    case (a)
      7'h04: return d0;
      7'h05: return (DC > 1) ? m_d1 : 32'd0;
      7'h10: return {m_hr, m_rr, 28'd0, m_ndm, m_act};
      7'h11: return 32'h82 | (running ? 32'hC00 : 0) | (halted ? 32'h300 : 0)
                   | (m_ra ? 32'h30000 : 0);
      7'h16: return DC | (32'(ce) << 8) | (b ? 32'h1000 : 0) | (PB ? 32'h0200_0000 : 0);
      7'h20: return PB ? m_pb0 : 32'd0;
      7'h21: return PB ? m_pb1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic m_cmd_ok(input logic [31:0] c);
    return c[31:24] == 0 && c[22:20] == 3'd2 && (PB || !c[18]);
  endfunction

  // Compare the current cycle against the model, then advance the model.
  task automatic model_step();
    logic b, ackv, lockw;
    logic [2:0] ce;
    logic [31:0] d0, er;
    ackv = m_busy & ack;
    b    = m_busy & ~ack;
    ce   = m_cerr;
    d0   = m_d0;
    if (ackv) begin
      if (err) ce = 3'd3;
      else if (m_cmd[17] && !m_cmd[16]) d0 = ackdata;
    end
    er = (req && !wr) ? m_read(addr, b, ce, d0) : 32'd0;
    chk("resp", 32'(resp), 32'(req));
    chk("rdata", rdata, er);
    chk("cmd_req", 32'(cmd_req_o), 32'(m_busy & ~ack & ~rst));
    chk("haltreq", 32'(haltreq_o), 32'(m_hr));
    chk("resumereq", 32'(resumereq_o), 32'(m_rr));
    chk("ndmreset", 32'(ndmreset_o), 32'(m_ndm));
    chk("dmactive", 32'(dmactive_o), 32'(m_act));
    chk("cmd", cmd_o, m_cmd);
    chk("cmd_wdata", cmd_wdata_o, m_d0);
    last_rdata  = rdata;
    last_cmdreq = cmd_req_o;

    if (m_rr && running) begin m_rr = 0; m_ra = 1; end
    m_busy = b; m_cerr = ce; m_d0 = d0;
    if (req && wr) begin
      lockw = (addr == 7'h04) || (addr == 7'h05 && DC > 1) || (addr == 7'h17)
              || (PB && (addr == 7'h20 || addr == 7'h21));
      if (addr == 7'h10) begin
        m_act = wdata[0];
        m_ndm = wdata[0] & wdata[1];
        m_hr  = wdata[0] & wdata[31];
        if (wdata[0] && wdata[30] && !wdata[31]) begin m_rr = 1; m_ra = 0; end
      end else if (m_act) begin
        if (lockw && m_busy) begin
          if (m_cerr == 0) m_cerr = 3'd1;
        end else if (addr == 7'h16) begin
          m_cerr = m_cerr & ~wdata[10:8];
        end else if (addr == 7'h04) m_d0 = wdata;
        else if (addr == 7'h05 && DC > 1) m_d1 = wdata;
        else if (addr == 7'h20 && PB) m_pb0 = wdata;
        else if (addr == 7'h21 && PB) m_pb1 = wdata;
        else if (addr == 7'h17 && m_cerr == 0) begin
          if (!m_cmd_ok(wdata)) m_cerr = 3'd2;
          else if (!halted) m_cerr = 3'd4;
          else begin m_cmd = wdata; m_busy = 1; end
        end
      end
    end
    if (rst || (req && wr && addr == 7'h10 && !wdata[0])) m_clear();
  endtask

  task automatic cyc(input logic r, input logic w, input logic [6:0] a, input logic [31:0] d);
    req = r; wr = w; addr = a; wdata = d;
    @(negedge clk);
    model_step();
    @(posedge clk); #1;
    ack = 0; err = 0; req = 0;
  endtask

  logic [6:0] atab [10] = '{7'h04, 7'h05, 7'h10, 7'h11, 7'h16, 7'h17, 7'h20, 7'h21, 7'h00, 7'h12};
  logic [31:0] ctab [6] = '{32'h00220010, 32'h00230010, 32'h00260010,
                            32'h01220010, 32'h00320010, 32'h00220011};

  initial begin
    m_clear();
    repeat (2) @(posedge clk);
    #1;
    running = 1; halted = 0;
    cyc(0, 0, 0, 0);
    rst = 0;

    // status readout straight after reset
    cyc(1, 0, 7'h11, 0);
    chk("tp_dmstatus", last_rdata, 32'h00000C82);

    // halt request, then deactivate clears everything
    cyc(1, 1, 7'h10, 32'h80000001);
    cyc(0, 0, 0, 0);
    chk("tp_haltreq", 32'(haltreq_o), 32'd1);
    chk("tp_dmactive", 32'(dmactive_o), 32'd1);
    cyc(1, 1, 7'h10, 32'h0);
    cyc(1, 0, 7'h10, 0);
    chk("tp_dmctl_clr", last_rdata, 32'h0);

    // register write command completes without touching data0
    halted = 1; running = 0;
    cyc(1, 1, 7'h10, 32'h1);
    cyc(1, 1, 7'h04, 32'h1234);
    cyc(1, 1, 7'h17, 32'h00230010);
    cyc(1, 0, 7'h16, 0);
    chk("tp_busy", last_rdata, 32'h1002 | (PB ? 32'h0200_0000 : 0));
    chk("tp_cmdreq", 32'(last_cmdreq), 32'd1);
    ack = 1; ackdata = 32'hFFFF0000;
    cyc(0, 0, 0, 0);
    chk("tp_ackdrop", 32'(last_cmdreq), 32'd0);
    cyc(1, 0, 7'h04, 0);
    chk("tp_data0_keep", last_rdata, 32'h1234);

    // register read command returns into data0; write while busy flags cmderr
    cyc(1, 1, 7'h17, 32'h00220010);
    ack = 1; ackdata = 32'hDEADBEEF;
    cyc(0, 0, 0, 0);
    cyc(1, 0, 7'h04, 0);
    chk("tp_data0_rd", last_rdata, 32'hDEADBEEF);
    cyc(1, 1, 7'h17, 32'h00220010);
    cyc(1, 1, 7'h17, 32'h00220010);
    ack = 1;
    cyc(1, 0, 7'h16, 0);
    chk("tp_cmderr_busy", last_rdata, 32'h102 | (PB ? 32'h0200_0000 : 0));
    cyc(1, 1, 7'h16, 32'h700);
    cyc(1, 0, 7'h16, 0);
    chk("tp_cmderr_w1c", last_rdata, 32'h2 | (PB ? 32'h0200_0000 : 0));

    // not halted -> cmderr 4, later commands ignored
    halted = 0;
    cyc(1, 1, 7'h17, 32'h00220010);
    cyc(1, 1, 7'h17, 32'h01220010);
    cyc(1, 0, 7'h16, 0);
    chk("tp_cmderr_halt", last_rdata, 32'h402 | (PB ? 32'h0200_0000 : 0));
    chk("tp_no_req", 32'(last_cmdreq), 32'd0);
    cyc(1, 1, 7'h16, 32'h700);

    // resume handshake
    halted = 1; running = 0;
    cyc(1, 1, 7'h10, 32'h40000001);
    repeat (3) cyc(0, 0, 0, 0);
    chk("tp_resumereq", 32'(resumereq_o), 32'd1);
    halted = 0; running = 1;
    cyc(0, 0, 0, 0);
    cyc(1, 0, 7'h11, 0);
    chk("tp_resumeack", last_rdata, 32'h00030C82);
    chk("tp_resume_drop", 32'(resumereq_o), 32'd0);

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      logic [6:0]  a;
      logic [31:0] d;
      halted  = ($urandom_range(0, 3) != 0);
      running = ~halted ^ ($urandom_range(0, 7) == 0);
      ack     = m_busy ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 15) == 0);
      err     = ($urandom_range(0, 3) == 0);
      ackdata = $urandom;
      rst     = ($urandom_range(0, 199) == 0);
      a = atab[$urandom_range(0, 9)];
      d = $urandom;
      if (a == 7'h10)
        d = {d[31:30], 28'd0, d[1], ($urandom_range(0, 9) != 0)};
      else if (a == 7'h17 && $urandom_range(0, 3) != 0)
        d = ctab[$urandom_range(0, 5)];
      if (!m_act && $urandom_range(0, 1) == 0) begin a = 7'h10; d = 32'h1; end
      cyc($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, a, d);
      rst = 0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
